// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment constants are active-high {g,f,e,d,c,b,a}.
package seg_pkg;

   localparam int NUM_DIGITS = 8;
   localparam logic [6:0] OFF_SEG = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   // Digit i (7..1) is blanked when enabled and it and every digit above it are
   // zero; digit 0 always shows so a zero value still displays "0".
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] digits,
                                                     input logic en);
      logic [NUM_DIGITS-1:0] m;
      logic zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (digits[4*i +: 4] == 4'h0);
         m[i]       = en & zero_above;
      end
      return m;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      unique case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Scan-index driven 8-digit 7-segment display driver with anti-ghost blanking,
// frame-coherent digit snapshot and optional leading-zero blanking.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned BLANK_CYCLES = 4,
   parameter bit          LZ_DEFAULT   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  scan_idx,
   input  logic [31:0] digits_in,
   input  logic [7:0]  dp_in,
   input  logic        lz_en,
   output logic [7:0]  digit_sel_n,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        frame_start
);

   localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYCLES);

   state_t      state, state_d;
   logic [2:0]  idx_q;
   logic [3:0]  bcnt, bcnt_d;
   logic [31:0] snap;
   logic [7:0]  dp_snap;
   logic [7:0]  lzmask;
   logic        lz_q;

   logic        chg;
   logic        snap_load;
   logic        drive_en;
   logic [3:0]  cur_nibble;
   logic [6:0]  dec_seg;
   logic [6:0]  seg_nxt;

   assign chg = (scan_idx != idx_q);

   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d   = state;
      bcnt_d    = bcnt;
      snap_load = 1'b0;
      drive_en  = 1'b0;
      unique case (state)
         IDLE: begin
            state_d   = BLANK;
            bcnt_d    = BLANK_INIT;
            snap_load = 1'b1;
         end
         BLANK, DRIVE: begin
            if (chg) begin
               // Any index change (even mid-blank) restarts the dark interval.
               state_d   = BLANK;
               bcnt_d    = BLANK_INIT;
               snap_load = (scan_idx == 3'd0);
            end else if (state == DRIVE) begin
               drive_en = 1'b1;
            end else if (bcnt > 4'd1) begin
               bcnt_d = bcnt - 4'd1;
            end else begin
               state_d  = DRIVE;
               bcnt_d   = 4'd0;
               drive_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         bcnt  <= 4'd0;
         idx_q <= 3'd0;
      end else begin
         state <= state_d;
         bcnt  <= bcnt_d;
         idx_q <= scan_idx;
      end
   end

   // NOTE: the snapshot registers are reset as well, so a blanked or freshly
   // reset display never shows undefined digit data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap        <= 32'h0;
         dp_snap     <= 8'h0;
         lz_q        <= LZ_DEFAULT;
         lzmask      <= lz_mask(32'h0, LZ_DEFAULT);
         frame_start <= 1'b0;
      end else begin
         frame_start <= snap_load;
         if (snap_load) begin
            snap    <= digits_in;
            dp_snap <= dp_in;
            lz_q    <= lz_en;
            lzmask  <= lz_mask(digits_in, lz_en);
         end
      end
   end

   // One shared decoder on the digit currently selected.
   assign cur_nibble = snap[4*idx_q +: 4];

   seg7_decode u_dec (
      .nibble (cur_nibble),
      .seg    (dec_seg)
   );

   assign seg_nxt = lzmask[idx_q] ? OFF_SEG : ~dec_seg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_sel_n <= 8'hFF;
         seg_n       <= OFF_SEG;
         dp_n        <= 1'b1;
      end else if (drive_en) begin
         digit_sel_n <= ~(8'b1 << idx_q);
         seg_n       <= seg_nxt;
         dp_n        <= ~dp_snap[idx_q];
      end else begin
         digit_sel_n <= 8'hFF;
         seg_n       <= OFF_SEG;
         dp_n        <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (BLANK_CYCLES=4 main DUT,
// plus a BLANK_CYCLES=0 instance for the minimum-dark-time boundary).
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  scan_idx = 3'd0;
   logic [31:0] digits_in = 32'h0;
   logic [7:0]  dp_in = 8'h0;
   logic        lz_en = 1'b0;

   logic [7:0]  digit_sel_n, digit_sel_n0;
   logic [6:0]  seg_n, seg_n0;
   logic        dp_n, dp_n0;
   logic        frame_start, frame_start0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(.BLANK_CYCLES(4), .LZ_DEFAULT(1'b1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .scan_idx    (scan_idx),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .lz_en       (lz_en),
      .digit_sel_n (digit_sel_n),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .frame_start (frame_start)
   );

   seg_scan_driver #(.BLANK_CYCLES(0), .LZ_DEFAULT(1'b1)) u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .scan_idx    (scan_idx),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .lz_en       (lz_en),
      .digit_sel_n (digit_sel_n0),
      .seg_n       (seg_n0),
      .dp_n        (dp_n0),
      .frame_start (frame_start0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_out(input string tag, input logic [7:0] sel,
                             input logic [6:0] seg, input logic dp);
      check({tag, "_sel"}, 32'(digit_sel_n), 32'(sel));
      check({tag, "_seg"}, 32'(seg_n), 32'(seg));
      check({tag, "_dp"}, 32'(dp_n), 32'(dp));
   endtask

   task automatic expect_dark(input string tag);
      expect_out(tag, 8'hFF, 7'h7F, 1'b1);
   endtask

   // Move to a new index: dark for 4 edges, lit on the 5th.
   task automatic show(input string tag, input logic [2:0] idx, input logic [7:0] sel,
                       input logic [6:0] seg, input logic dp);
      scan_idx = idx;
      for (int k = 0; k < 4; k++) begin
         tick(1);
         expect_dark({tag, "_dark"});
      end
      tick(1);
      expect_out({tag, "_lit"}, sel, seg, dp);
   endtask

   logic [6:0] lz_seg_exp [8];
   logic       lz_dp_exp  [8];

   initial begin
      // 1. Reset held while the index toggles
      for (int i = 0; i < 4; i++) begin
         scan_idx = 3'(i + 1);
         tick(1);
         expect_dark("rst_hold");
         check("rst_hold_fs", 32'(frame_start), 32'd0);
      end
      scan_idx  = 3'd0;
      digits_in = 32'h12345678;
      tick(1);
      rst = 1'b0;

      // IDLE exit: forced snapshot, blank 4 cycles, then digit 0 ('8')
      tick(1);
      expect_dark("idle_exit");
      check("idle_exit_fs", 32'(frame_start), 32'd1);
      tick(1);
      check("idle_fs_drop", 32'(frame_start), 32'd0);
      expect_dark("idle_blank");
      tick(2);
      expect_dark("idle_blank_end");
      tick(1);
      expect_out("digit0_first", 8'hFE, 7'h00, 1'b1);

      // 2. 0 -> 1: dark 4 cycles then digit 1 = '7'; zero-blank DUT lit after 1
      scan_idx = 3'd1;
      tick(1);
      expect_dark("idx1_e0");
      check("b0_dark", 32'(digit_sel_n0), 32'hFF);
      tick(1);
      expect_dark("idx1_e1");
      check("b0_lit_sel", 32'(digit_sel_n0), 32'hFD);
      check("b0_lit_seg", 32'(seg_n0), 32'h78);
      tick(2);
      expect_dark("idx1_e3");
      tick(1);
      expect_out("idx1_lit", 8'hFD, 7'h78, 1'b1);
      tick(2);
      expect_out("idx1_stable", 8'hFD, 7'h78, 1'b1);

      // 3. New data mid-frame is ignored until the index returns to 0
      digits_in = 32'h0;
      show("idx3", 3'd3, 8'hF7, 7'h12, 1'b1);
      check("idx3_no_fs", 32'(frame_start), 32'd0);
      scan_idx = 3'd0;
      tick(1);
      check("snap_fs", 32'(frame_start), 32'd1);
      tick(1);
      check("snap_fs_once", 32'(frame_start), 32'd0);
      tick(2);
      expect_dark("snap_dark");
      tick(1);
      expect_out("snap_digit0", 8'hFE, 7'h40, 1'b1);

      // 4. Leading-zero blanking on 00000405, dp on digits 1 and 7
      digits_in = 32'h00000405;
      dp_in     = 8'h82;
      lz_en     = 1'b1;
      show("lz_pre", 3'd1, 8'hFD, 7'h40, 1'b1);
      show("lz_d0", 3'd0, 8'hFE, 7'h12, 1'b1);
      lz_seg_exp = '{7'h12, 7'h40, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      lz_dp_exp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 1; i < 8; i++) begin
         show($sformatf("lz_d%0d", i), 3'(i), ~(8'h01 << i), lz_seg_exp[i], lz_dp_exp[i]);
      end

      // 5. Change again 2 cycles into BLANK restarts the interval
      scan_idx = 3'd5;
      tick(1);
      expect_dark("restart_a0");
      tick(1);
      expect_dark("restart_a1");
      show("restart_b", 3'd2, 8'hFB, 7'h19, 1'b1);

      // 6. Asynchronous reset while driving
      #2;
      rst = 1'b1;
      #1;
      expect_dark("async_rst");
      check("async_rst_fs", 32'(frame_start), 32'd0);
      check("async_rst_b0", 32'(digit_sel_n0), 32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
